// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave terminating a bank of NUM_REGS read/write control registers.
// Write and read channels run independently; each holds at most one transaction.
module axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 wr_pulse_q, wr_pulse_d;
  logic                                aw_held_q, aw_held_d;
  logic                                w_held_q, w_held_d;
  logic [IDX_W-1:0]                    awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0]               wdata_q, wdata_d;
  logic [STRB_W-1:0]                   wstrb_q, wstrb_d;
  logic                                bvalid_q, bvalid_d;
  logic [1:0]                          bresp_q, bresp_d;
  logic                                rvalid_q, rvalid_d;
  logic [1:0]                          rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]               rdata_q, rdata_d;

  logic             aw_hs, w_hs, ar_hs, commit, w_in_range, r_in_range;
  logic [IDX_W-1:0] ridx;

  // Byte-offset address bits never take part in decode; misaligned accesses alias.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_awaddr[LSB-1:0], s_araddr[LSB-1:0]};

  assign s_awready = !aw_held_q && !bvalid_q;
  assign s_wready  = !w_held_q && !bvalid_q;
  assign s_arready = !rvalid_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign regs_out  = regs_q;
  assign wr_pulse  = wr_pulse_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    aw_hs = s_awvalid && s_awready;
    w_hs  = s_wvalid && s_wready;
    ar_hs = s_arvalid && s_arready;

    // Effective AW/W: a fresh handshake this cycle, otherwise the held copy.
    awidx_d = aw_hs ? s_awaddr[ADDR_WIDTH-1:LSB] : awidx_q;
    wdata_d = w_hs ? s_wdata : wdata_q;
    wstrb_d = w_hs ? s_wstrb : wstrb_q;

    commit     = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    aw_held_d  = (aw_held_q || aw_hs) && !commit;
    w_held_d   = (w_held_q || w_hs) && !commit;
    w_in_range = 32'(awidx_d) < 32'(NUM_REGS);

    regs_d     = regs_q;
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit && awidx_d == IDX_W'(i) && |wstrb_d) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_d[b]) regs_d[i][b*8 +: 8] = wdata_d[b*8 +: 8];
        end
      end
    end

    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = w_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_bready) begin
      bvalid_d = 1'b0;
    end

    // Reads sample regs_q, so a same-edge write to the same register is not seen.
    ridx       = s_araddr[ADDR_WIDTH-1:LSB];
    r_in_range = 32'(ridx) < 32'(NUM_REGS);
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = r_in_range ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ridx == IDX_W'(i)) rdata_d = regs_q[i];
      end
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // NOTE: the register bank is a handful of flops, not RAM, so it is reset along with the rest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q     <= '0;
      wr_pulse_q <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: a table of write/read-back vectors plus
// hand-written sequences for split channels, backpressure, collision and reset.
module tb_axil_reg_slave;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NR = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  s_awaddr;
  logic           s_awvalid, s_awready;
  logic [DW-1:0]  s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic           s_wvalid, s_wready;
  logic [1:0]     s_bresp;
  logic           s_bvalid, s_bready;
  logic [AW-1:0]  s_araddr;
  logic           s_arvalid, s_arready;
  logic [DW-1:0]  s_rdata;
  logic [1:0]     s_rresp;
  logic           s_rvalid, s_rready;
  logic [NR*DW-1:0] regs_out;
  logic [NR-1:0]  wr_pulse;

  axil_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .regs_out(regs_out), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [3:0]     strb;
    logic [1:0]     bresp;
    logic [NR-1:0]  pulse;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
  } vec_t;

  vec_t          vecs[7];
  logic [DW-1:0] model[NR];
  int            n_cmp  = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) check($sformatf("%s_reg%0d", tag, i), regs_out[i*DW +: DW], model[i]);
  endtask

  initial begin
    vecs[0] = '{12'h008, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0004, 32'hDEADBEEF, 2'b00};
    vecs[1] = '{12'h004, 32'hAAAAAAAA, 4'hF, 2'b00, 16'h0002, 32'hAAAAAAAA, 2'b00};
    vecs[2] = '{12'h040, 32'h12345678, 4'hF, 2'b10, 16'h0000, 32'h00000000, 2'b10};
    vecs[3] = '{12'h00E, 32'h00000005, 4'hF, 2'b00, 16'h0008, 32'h00000005, 2'b00};
    vecs[4] = '{12'h03C, 32'hCAFEF00D, 4'h3, 2'b00, 16'h8000, 32'h0000F00D, 2'b00};
    vecs[5] = '{12'h008, 32'hFFFFFFFF, 4'h0, 2'b00, 16'h0000, 32'hDEADBEEF, 2'b00};
    vecs[6] = '{12'hFFC, 32'h01010101, 4'hF, 2'b10, 16'h0000, 32'h00000000, 2'b10};
    for (int i = 0; i < NR; i++) model[i] = '0;

    reset = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b1; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b1;
    #22 reset = 1'b1;
    step();

    check("rst_awready", s_awready, 1);
    check("rst_wready",  s_wready,  1);
    check("rst_bvalid",  s_bvalid,  0);
    check("rst_rvalid",  s_rvalid,  0);
    check_regs("rst");

    // Table: same-cycle AW+W, check B and pulse, then read back.
    for (int v = 0; v < 7; v++) begin
      s_awaddr = vecs[v].addr; s_awvalid = 1'b1;
      s_wdata = vecs[v].data; s_wstrb = vecs[v].strb; s_wvalid = 1'b1;
      step();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      for (int i = 0; i < NR; i++) if (vecs[v].pulse[i]) model[i] = vecs[v].rdata;
      check($sformatf("v%0d_bvalid", v), s_bvalid, 1);
      check($sformatf("v%0d_bresp", v), s_bresp, vecs[v].bresp);
      check($sformatf("v%0d_pulse", v), wr_pulse, vecs[v].pulse);
      check_regs($sformatf("v%0d", v));
      step();
      check($sformatf("v%0d_bvalid_clr", v), s_bvalid, 0);
      check($sformatf("v%0d_pulse_clr", v), wr_pulse, 0);
      s_araddr = vecs[v].addr; s_arvalid = 1'b1;
      step();
      s_arvalid = 1'b0;
      check($sformatf("v%0d_rvalid", v), s_rvalid, 1);
      check($sformatf("v%0d_rdata", v), s_rdata, vecs[v].rdata);
      check($sformatf("v%0d_rresp", v), s_rresp, vecs[v].rresp);
      step();
      check($sformatf("v%0d_rvalid_clr", v), s_rvalid, 0);
    end

    // Split: W first with partial strobes, AW three cycles later.
    s_wdata = 32'h11223344; s_wstrb = 4'b0101; s_wvalid = 1'b1;
    step();
    s_wvalid = 1'b0;
    check("split_wready_held", s_wready, 0);
    check("split_bvalid_w_only", s_bvalid, 0);
    step();
    check("split_bvalid_wait1", s_bvalid, 0);
    step();
    check("split_bvalid_wait2", s_bvalid, 0);
    s_awaddr = 12'h004; s_awvalid = 1'b1;
    step();
    s_awvalid = 1'b0;
    check("split_bvalid", s_bvalid, 1);
    check("split_bresp", s_bresp, 2'b00);
    check("split_reg1", regs_out[1*DW +: DW], 32'hAA22AA44);
    check("split_pulse", wr_pulse, 16'h0002);
    step();

    // B backpressure: response and ready lines frozen for 5 cycles.
    s_bready = 1'b0;
    s_awaddr = 12'h008; s_awvalid = 1'b1; s_wdata = 32'h00001234; s_wstrb = 4'hF; s_wvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_b_cyc%0d", c), {s_bvalid, s_bresp, s_awready, s_wready}, 5'b1_00_00);
      step();
    end
    s_bready = 1'b1;
    check("bp_b_release_bvalid", s_bvalid, 1);
    step();
    check("bp_b_cleared", s_bvalid, 0);

    // R backpressure while a write to reg4 completes.
    s_rready = 1'b0;
    s_araddr = 12'h008; s_arvalid = 1'b1;
    step();
    s_arvalid = 1'b0;
    check("bp_r_rvalid", s_rvalid, 1);
    check("bp_r_rdata", s_rdata, 32'h00001234);
    s_awaddr = 12'h010; s_awvalid = 1'b1; s_wdata = 32'h00000077; s_wstrb = 4'hF; s_wvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("bp_r_wr_bvalid", s_bvalid, 1);
    check("bp_r_hold", {s_rvalid, s_arready}, 2'b10);
    check("bp_r_rdata_hold", s_rdata, 32'h00001234);
    step();
    check("bp_r_wr_done", s_bvalid, 0);
    check("bp_r_reg4", regs_out[4*DW +: DW], 32'h00000077);
    check("bp_r_rdata_hold2", s_rdata, 32'h00001234);
    s_rready = 1'b1;
    step();
    check("bp_r_cleared", s_rvalid, 0);

    // Collision: write and read of reg3 commit on the same edge.
    s_awaddr = 12'h00C; s_awvalid = 1'b1; s_wdata = 32'h00000009; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_araddr = 12'h00C; s_arvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    check("coll_rdata_old", s_rdata, 32'h00000005);
    check("coll_bvalid", s_bvalid, 1);
    step();
    s_arvalid = 1'b1;
    step();
    s_arvalid = 1'b0;
    check("coll_rdata_new", s_rdata, 32'h00000009);
    step();

    // Reset while AW is held without W.
    s_awaddr = 12'h000; s_awvalid = 1'b1;
    step();
    s_awvalid = 1'b0;
    check("rst2_aw_held", s_awready, 0);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    check("rst2_bvalid", s_bvalid, 0);
    check("rst2_rvalid", s_rvalid, 0);
    check("rst2_pulse", wr_pulse, 0);
    check_regs("rst2");
    @(negedge clk);
    reset = 1'b1;
    step();
    check("rst2_awready", s_awready, 1);
    check("rst2_wready", s_wready, 1);
    s_wdata = 32'hFFFFFFFF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    step();
    s_wvalid = 1'b0;
    check("rst2_aw_discarded", s_bvalid, 0);
    check("rst2_reg0", regs_out[0 +: DW], 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
